// File: rtl/prbs_bert_ctrl.sv
// PRBS7 bit-error-rate test sequencer: settles the link, waits for checker
// alignment, then accumulates per-word bit errors over a programmed run length.
module prbs_bert_ctrl #(
  parameter int RUN_W         = 32,
  parameter int ERR_W         = 32,
  parameter int SETTLE_CYCLES = 16,
  parameter int ALIGN_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [RUN_W-1:0] run_len,
  input  logic             aligned,
  input  logic [5:0]       err_in,
  output logic             prbs_dis,
  output logic             chk_rst,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             lol,
  output logic [ERR_W-1:0] err_total,
  output logic [RUN_W-1:0] word_cnt,
  output logic [2:0]       state
);

  localparam int CNT_MAX = (SETTLE_CYCLES > ALIGN_TIMEOUT) ? SETTLE_CYCLES : ALIGN_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALIGN_LAST  = CNT_W'(ALIGN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SETTLE     = 3'd1,
    WAIT_ALIGN = 3'd2,
    RUN        = 3'd3,
    DONE       = 3'd4,
    FAIL       = 3'd5
  } state_t;

  state_t           cur, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [RUN_W-1:0] run_len_q, run_len_nxt;
  logic [RUN_W-1:0] word_cnt_nxt, word_cnt_inc;
  logic [ERR_W-1:0] err_total_nxt, err_total_acc;
  logic             done_nxt, timeout_nxt, lol_nxt;
  logic             busy_nxt, prbs_dis_nxt, chk_rst_nxt;

  function automatic logic [ERR_W-1:0] sat_add_err(input logic [ERR_W-1:0] acc,
                                                   input logic [5:0] add);
    logic [ERR_W:0] sum;
    sum = {1'b0, acc} + {{(ERR_W-5){1'b0}}, add};
    return sum[ERR_W] ? {ERR_W{1'b1}} : sum[ERR_W-1:0];
  endfunction

  function automatic logic [RUN_W-1:0] sat_inc_cnt(input logic [RUN_W-1:0] v);
    return (&v) ? v : v + RUN_W'(1);
  endfunction

  assign err_total_acc = sat_add_err(err_total, err_in);
  assign word_cnt_inc  = sat_inc_cnt(word_cnt);
  assign state         = cur;

  always_comb begin
    nxt           = cur;
    cnt_nxt       = cnt;
    run_len_nxt   = run_len_q;
    err_total_nxt = err_total;
    word_cnt_nxt  = word_cnt;
    done_nxt      = done;
    timeout_nxt   = timeout;
    lol_nxt       = lol;
    case (cur)
      IDLE, DONE, FAIL: begin
        if (start && !abort) begin
          nxt           = SETTLE;
          cnt_nxt       = '0;
          run_len_nxt   = run_len;
          err_total_nxt = '0;
          word_cnt_nxt  = '0;
          done_nxt      = 1'b0;
          timeout_nxt   = 1'b0;
          lol_nxt       = 1'b0;
        end
      end
      SETTLE: begin
        if (abort) begin
          nxt = IDLE;
        end else if (cnt == SETTLE_LAST) begin
          nxt     = WAIT_ALIGN;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      WAIT_ALIGN: begin
        if (abort) begin
          nxt = IDLE;
        end else if (aligned) begin
          nxt = RUN;
        end else if (cnt == ALIGN_LAST) begin
          nxt         = FAIL;
          timeout_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        // abort beats completion; lost alignment skips this word's accumulation
        if (abort) begin
          nxt = IDLE;
        end else if (!aligned) begin
          nxt     = FAIL;
          lol_nxt = 1'b1;
        end else begin
          err_total_nxt = err_total_acc;
          word_cnt_nxt  = word_cnt_inc;
          if ((run_len_q != '0) && (word_cnt_inc == run_len_q)) begin
            nxt      = DONE;
            done_nxt = 1'b1;
          end
        end
      end
      default: nxt = IDLE;
    endcase

    busy_nxt     = (nxt == SETTLE) || (nxt == WAIT_ALIGN) || (nxt == RUN);
    prbs_dis_nxt = !busy_nxt;
    chk_rst_nxt  = (nxt != WAIT_ALIGN) && (nxt != RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur       <= IDLE;
      cnt       <= '0;
      run_len_q <= '0;
      err_total <= '0;
      word_cnt  <= '0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      lol       <= 1'b0;
      busy      <= 1'b0;
      prbs_dis  <= 1'b1;
      chk_rst   <= 1'b1;
    end else begin
      cur       <= nxt;
      cnt       <= cnt_nxt;
      run_len_q <= run_len_nxt;
      err_total <= err_total_nxt;
      word_cnt  <= word_cnt_nxt;
      done      <= done_nxt;
      timeout   <= timeout_nxt;
      lol       <= lol_nxt;
      busy      <= busy_nxt;
      prbs_dis  <= prbs_dis_nxt;
      chk_rst   <= chk_rst_nxt;
    end
  end

endmodule

// File: tb/tb_prbs_bert_ctrl.sv
// Bench for prbs_bert_ctrl: default-width instance plus an 8-bit error
// accumulator instance, both driven by the same stimulus.
module tb_prbs_bert_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, abort, aligned;
  logic [31:0] run_len;
  logic [5:0]  err_in;

  logic        prbs_dis, chk_rst, busy, done, timeout, lol;
  logic [31:0] err_total, word_cnt;
  logic [2:0]  state;
  logic        s_prbs_dis, s_chk_rst, s_busy, s_done, s_timeout, s_lol;
  logic [7:0]  s_err_total;
  logic [31:0] s_word_cnt;
  logic [2:0]  s_state;

  wire [8:0] stat   = {state, busy, prbs_dis, chk_rst, done, timeout, lol};
  wire [8:0] s_stat = {s_state, s_busy, s_prbs_dis, s_chk_rst, s_done, s_timeout, s_lol};

  // {state, busy, prbs_dis, chk_rst, done, timeout, lol}
  localparam logic [8:0] ST_IDLE   = {3'd0, 6'b011000};
  localparam logic [8:0] ST_SETTLE = {3'd1, 6'b101000};
  localparam logic [8:0] ST_WAIT   = {3'd2, 6'b100000};
  localparam logic [8:0] ST_RUN    = {3'd3, 6'b100000};
  localparam logic [8:0] ST_DONE   = {3'd4, 6'b011100};
  localparam logic [8:0] ST_TMO    = {3'd5, 6'b011010};
  localparam logic [8:0] ST_LOL    = {3'd5, 6'b011001};

  typedef struct {
    logic [31:0] err;
    logic [7:0]  err8;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        x;
  logic [31:0] m_err, m_cnt;
  logic [7:0]  m_err8;
  int          checks = 0;
  int          errors = 0;

  prbs_bert_ctrl u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .run_len(run_len),
    .aligned(aligned), .err_in(err_in), .prbs_dis(prbs_dis), .chk_rst(chk_rst),
    .busy(busy), .done(done), .timeout(timeout), .lol(lol),
    .err_total(err_total), .word_cnt(word_cnt), .state(state)
  );

  prbs_bert_ctrl #(.ERR_W(8)) u_sat (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .run_len(run_len),
    .aligned(aligned), .err_in(err_in), .prbs_dis(s_prbs_dis), .chk_rst(s_chk_rst),
    .busy(s_busy), .done(s_done), .timeout(s_timeout), .lol(s_lol),
    .err_total(s_err_total), .word_cnt(s_word_cnt), .state(s_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [31:0] len);
    start   = 1'b1;
    run_len = len;
    tick();
    start   = 1'b0;
    m_err   = '0;
    m_err8  = '0;
    m_cnt   = '0;
    sb.delete();
  endtask

  // drive one aligned word and queue the counter values it should produce
  task automatic push_word(input logic [5:0] e);
    int s8;
    err_in  = e;
    aligned = 1'b1;
    m_err   = m_err + 32'(e);
    s8      = int'(m_err8) + int'(e);
    m_err8  = (s8 > 255) ? 8'hFF : 8'(s8);
    m_cnt   = m_cnt + 1;
    sb.push_back('{err: m_err, err8: m_err8, cnt: m_cnt});
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; abort = 1'b0; aligned = 1'b0;
    run_len = '0; err_in = '0;
    repeat (2) tick();
    checks++;
    if ({stat, err_total, word_cnt} !== {ST_IDLE, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_values: got stat=%b err=%0d cnt=%0d required stat=%b err=0 cnt=0",
               stat, err_total, word_cnt, ST_IDLE);
    end
    reset = 1'b1;
    repeat (2) tick();
    checks++;
    if (stat !== ST_IDLE) begin
      errors++;
      $display("FAIL idle_after_reset: got %b required %b", stat, ST_IDLE);
    end
  endtask

  task automatic test_normal;
    start_run(100);
    checks++;
    if (stat !== ST_SETTLE) begin
      errors++;
      $display("FAIL normal_settle_entry: got %b required %b", stat, ST_SETTLE);
    end
    repeat (15) tick();
    checks++;
    if (stat !== ST_SETTLE) begin
      errors++;
      $display("FAIL normal_settle_last: got %b required %b", stat, ST_SETTLE);
    end
    tick();
    checks++;
    if (stat !== ST_WAIT) begin
      errors++;
      $display("FAIL normal_wait_entry: got %b required %b", stat, ST_WAIT);
    end
    repeat (13) tick();
    aligned = 1'b1;
    tick();
    checks++;
    if ({stat, word_cnt} !== {ST_RUN, 32'd0}) begin
      errors++;
      $display("FAIL normal_run_entry: got stat=%b cnt=%0d required stat=%b cnt=0",
               stat, word_cnt, ST_RUN);
    end
    for (int w = 1; w <= 100; w++) begin
      push_word((w == 50) ? 6'd3 : (w == 99) ? 6'd32 : 6'd0);
      tick();
      x = sb.pop_front();
      checks++;
      if ({err_total, s_err_total, word_cnt, s_word_cnt} !== {x.err, x.err8, x.cnt, x.cnt}) begin
        errors++;
        $display("FAIL normal_word%0d: got err=%0d err8=%0d cnt=%0d required err=%0d err8=%0d cnt=%0d",
                 w, err_total, s_err_total, word_cnt, x.err, x.err8, x.cnt);
      end
    end
    aligned = 1'b0; err_in = '0;
    checks++;
    if ({stat, s_stat, err_total, word_cnt} !== {ST_DONE, ST_DONE, 32'd35, 32'd100}) begin
      errors++;
      $display("FAIL normal_done: got stat=%b s_stat=%b err=%0d cnt=%0d required stat=%b err=35 cnt=100",
               stat, s_stat, err_total, word_cnt, ST_DONE);
    end
  endtask

  task automatic test_timeout;
    start_run(5);
    repeat (16) tick();
    checks++;
    if ({stat, err_total} !== {ST_WAIT, 32'd0}) begin
      errors++;
      $display("FAIL timeout_wait_entry: got stat=%b err=%0d required stat=%b err=0",
               stat, err_total, ST_WAIT);
    end
    repeat (1023) tick();
    checks++;
    if (stat !== ST_WAIT) begin
      errors++;
      $display("FAIL timeout_early: got %b required %b", stat, ST_WAIT);
    end
    tick();
    checks++;
    if ({stat, s_stat, word_cnt} !== {ST_TMO, ST_TMO, 32'd0}) begin
      errors++;
      $display("FAIL timeout_fail: got stat=%b s_stat=%b cnt=%0d required stat=%b cnt=0",
               stat, s_stat, word_cnt, ST_TMO);
    end
  endtask

  task automatic test_lol;
    start_run(100);
    repeat (16) tick();
    aligned = 1'b1;
    tick();
    checks++;
    if (stat !== ST_RUN) begin
      errors++;
      $display("FAIL lol_run_entry: got %b required %b", stat, ST_RUN);
    end
    for (int w = 1; w <= 40; w++) begin
      push_word(6'd1);
      tick();
      x = sb.pop_front();
      checks++;
      if ({err_total, s_err_total, word_cnt} !== {x.err, x.err8, x.cnt}) begin
        errors++;
        $display("FAIL lol_word%0d: got err=%0d cnt=%0d required err=%0d cnt=%0d",
                 w, err_total, word_cnt, x.err, x.cnt);
      end
    end
    aligned = 1'b0; err_in = 6'd1;
    tick();
    checks++;
    if ({stat, err_total, word_cnt} !== {ST_LOL, 32'd40, 32'd40}) begin
      errors++;
      $display("FAIL lol_fail: got stat=%b err=%0d cnt=%0d required stat=%b err=40 cnt=40",
               stat, err_total, word_cnt, ST_LOL);
    end
    err_in = '0;
  endtask

  task automatic test_saturation;
    start_run(20);
    repeat (16) tick();
    aligned = 1'b1;
    tick();
    for (int w = 1; w <= 20; w++) begin
      push_word(6'd32);
      tick();
      x = sb.pop_front();
      checks++;
      if ({err_total, s_err_total, s_word_cnt} !== {x.err, x.err8, x.cnt}) begin
        errors++;
        $display("FAIL sat_word%0d: got err=%0d err8=%0d cnt=%0d required err=%0d err8=%0d cnt=%0d",
                 w, err_total, s_err_total, s_word_cnt, x.err, x.err8, x.cnt);
      end
    end
    aligned = 1'b0; err_in = '0;
    checks++;
    if ({s_stat, s_err_total, s_word_cnt, err_total} !== {ST_DONE, 8'd255, 32'd20, 32'd640}) begin
      errors++;
      $display("FAIL sat_done: got s_stat=%b err8=%0d cnt=%0d err=%0d required s_stat=%b err8=255 cnt=20 err=640",
               s_stat, s_err_total, s_word_cnt, err_total, ST_DONE);
    end
    start = 1'b1; abort = 1'b1; run_len = 32'd7;
    tick();
    start = 1'b0; abort = 1'b0;
    checks++;
    if ({s_stat, s_err_total, s_word_cnt} !== {ST_DONE, 8'd255, 32'd20}) begin
      errors++;
      $display("FAIL start_abort_in_done: got s_stat=%b err8=%0d cnt=%0d required s_stat=%b err8=255 cnt=20",
               s_stat, s_err_total, s_word_cnt, ST_DONE);
    end
  endtask

  task automatic test_abort;
    start_run(10);
    repeat (16) tick();
    aligned = 1'b1;
    tick();
    for (int w = 1; w <= 9; w++) begin
      push_word(6'd1);
      if (w == 5) begin
        start = 1'b1; run_len = 32'd3;
      end
      tick();
      start = 1'b0;
      x = sb.pop_front();
      checks++;
      if ({stat, err_total, word_cnt} !== {ST_RUN, x.err, x.cnt}) begin
        errors++;
        $display("FAIL abort_word%0d: got stat=%b err=%0d cnt=%0d required stat=%b err=%0d cnt=%0d",
                 w, stat, err_total, word_cnt, ST_RUN, x.err, x.cnt);
      end
    end
    err_in = 6'd5; aligned = 1'b1; abort = 1'b1;
    tick();
    abort = 1'b0; aligned = 1'b0; err_in = '0;
    checks++;
    if ({stat, err_total, word_cnt} !== {ST_IDLE, 32'd9, 32'd9}) begin
      errors++;
      $display("FAIL abort_final_word: got stat=%b err=%0d cnt=%0d required stat=%b err=9 cnt=9",
               stat, err_total, word_cnt, ST_IDLE);
    end
    start = 1'b1; abort = 1'b1; run_len = 32'd4;
    tick();
    start = 1'b0; abort = 1'b0;
    tick();
    checks++;
    if ({stat, err_total, word_cnt} !== {ST_IDLE, 32'd9, 32'd9}) begin
      errors++;
      $display("FAIL start_abort_in_idle: got stat=%b err=%0d cnt=%0d required stat=%b err=9 cnt=9",
               stat, err_total, word_cnt, ST_IDLE);
    end
  endtask

  task automatic test_reset_midrun;
    start_run(0);
    repeat (16) tick();
    aligned = 1'b1;
    tick();
    repeat (10) begin
      push_word(6'(3));
      tick();
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({stat, s_stat, err_total, word_cnt} !== {ST_IDLE, ST_IDLE, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL async_reset: got stat=%b s_stat=%b err=%0d cnt=%0d required stat=%b err=0 cnt=0",
               stat, s_stat, err_total, word_cnt, ST_IDLE);
    end
    aligned = 1'b0; err_in = '0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_continuous;
    start_run(0);
    repeat (16) tick();
    aligned = 1'b1;
    tick();
    for (int w = 1; w <= 300; w++) begin
      push_word(6'($urandom_range(0, 32)));
      tick();
      x = sb.pop_front();
      checks++;
      if ({stat, err_total, s_err_total, word_cnt} !== {ST_RUN, x.err, x.err8, x.cnt}) begin
        errors++;
        $display("FAIL cont_word%0d: got stat=%b err=%0d err8=%0d cnt=%0d required stat=%b err=%0d err8=%0d cnt=%0d",
                 w, stat, err_total, s_err_total, word_cnt, ST_RUN, x.err, x.err8, x.cnt);
      end
    end
    abort = 1'b1;
    tick();
    abort = 1'b0; aligned = 1'b0; err_in = '0;
    checks++;
    if ({stat, err_total, word_cnt} !== {ST_IDLE, m_err, 32'd300}) begin
      errors++;
      $display("FAIL cont_abort: got stat=%b err=%0d cnt=%0d required stat=%b err=%0d cnt=300",
               stat, err_total, word_cnt, ST_IDLE, m_err);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_timeout();
    test_lol();
    test_saturation();
    test_abort();
    test_reset_midrun();
    test_continuous();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
